freq_histogram: RTL and testbench

FREQ_HISTOGRAM -- requirements
Module: freq_histogram

---
 rtl/huff_pkg.sv | 25 ++
 rtl/sat_counter.sv | 36 +++
 rtl/freq_histogram.sv | 184 ++++++++++++++++++
 tb/tb_freq_histogram.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Definitions shared by the histogram block and the coding stage that follows it:
// the state encoding, default sizes and the index-width helper.
package huff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } hist_state_e;

    localparam int DEF_NUM_SYM = 10;
    localparam int DEF_SYM_W   = 4;
    localparam int DEF_CNT_W   = 8;

    // ceil(log2(n)), but never less than 1, so a symbol index always has a bit
    function automatic int idx_bits(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. sat_hit flags an increment
// that arrived while the counter was already at its maximum.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    assign at_max  = &cnt_q;
    assign sat_hit = inc && at_max && !clr;
    assign cnt     = cnt_q;

    // clear wins over increment; increments at the maximum are dropped
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !at_max)
            cnt_d = cnt_q + W'(1);
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/freq_histogram.sv
// Symbol frequency histogram: counts a stream of symbols, then drains the
// per-symbol counts in ascending index order over a valid/ready port.
module freq_histogram
    import huff_pkg::*;
#(
    parameter  int NUM_SYM = DEF_NUM_SYM,
    parameter  int SYM_W   = DEF_SYM_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int IDX_W   = idx_bits(NUM_SYM),
    localparam int TOT_W   = CNT_W + IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             skip_zero,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [SYM_W-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_sym,
    output logic [CNT_W-1:0] out_freq,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [TOT_W-1:0] total,
    output logic             err_range,
    output logic             sat_flag
);

    localparam logic [SYM_W:0]   NSYM     = (SYM_W+1)'(NUM_SYM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

    hist_state_e state_q, state_d;
    logic             skip_q, skip_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             err_q, err_d, sat_q, sat_d;
    logic             done_q, done_d, busy_q, busy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             scan_done_q, scan_done_d;
    logic             ov_q, ov_d, olast_q, olast_d;
    logic [IDX_W-1:0] osym_q, osym_d;
    logic [CNT_W-1:0] ofreq_q, ofreq_d;

    logic [NUM_SYM-1:0]            inc, sat_hit, nz;
    logic [NUM_SYM-1:0][CNT_W-1:0] cnt;
    logic             clr, take, in_range, slot_free, higher_nz, last_entry;
    logic [CNT_W-1:0] cur_cnt;

    assign clr       = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign take      = in_valid && (state_q == ST_COUNT);
    assign in_range  = {1'b0, data_in} < NSYM;
    assign slot_free = !ov_q || out_ready;
    assign cur_cnt   = cnt[idx_q];

    for (genvar i = 0; i < NUM_SYM; i++) begin : g_cnt
        assign inc[i] = take && in_range && (data_in == SYM_W'(i));
        assign nz[i]  = |cnt[i];
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .inc     (inc[i]),
            .cnt     (cnt[i]),
            .sat_hit (sat_hit[i])
        );
    end

    // any nonzero count above the scan pointer decides out_last in skip mode
    always_comb begin
        higher_nz = 1'b0;
        for (int i = 0; i < NUM_SYM; i++)
            if (nz[i] && (IDX_W'(i) > idx_q)) higher_nz = 1'b1;
    end

    assign last_entry = skip_q ? !higher_nz : (idx_q == LAST_IDX);

    // next-state: count phase, then a scan that refills the output slot whenever it frees
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        total_d     = total_q;
        err_d       = err_q;
        sat_d       = sat_q;
        idx_d       = idx_q;
        scan_done_d = scan_done_q;
        ov_d        = ov_q;
        osym_d      = osym_q;
        ofreq_d     = ofreq_q;
        olast_d     = olast_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_COUNT;
                    skip_d  = skip_zero;
                    total_d = '0;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (in_valid) begin
                    if (!in_range)
                        err_d = 1'b1;
                    else if (total_q != '1)
                        total_d = total_q + TOT_W'(1);
                    if (in_last) begin
                        state_d     = ST_DRAIN;
                        idx_d       = '0;
                        scan_done_d = 1'b0;
                    end
                end
                if (|sat_hit) sat_d = 1'b1;
            end
            ST_DRAIN: begin
                if (slot_free) begin
                    ov_d    = 1'b0;
                    olast_d = 1'b0;
                    if (scan_done_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // a zero entry in skip mode just costs this one cycle
                        if (!skip_q || cur_cnt != '0) begin
                            ov_d    = 1'b1;
                            osym_d  = idx_q;
                            ofreq_d = cur_cnt;
                            olast_d = last_entry;
                        end
                        if (last_entry) scan_done_d = 1'b1;
                        else            idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_COUNT) || (state_d == ST_DRAIN);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            skip_q      <= 1'b0;
            total_q     <= '0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            scan_done_q <= 1'b0;
            ov_q        <= 1'b0;
            osym_q      <= '0;
            ofreq_q     <= '0;
            olast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            total_q     <= total_d;
            err_q       <= err_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            scan_done_q <= scan_done_d;
            ov_q        <= ov_d;
            osym_q      <= osym_d;
            ofreq_q     <= ofreq_d;
            olast_q     <= olast_d;
        end
    end

    assign out_valid = ov_q;
    assign out_sym   = osym_q;
    assign out_freq  = ofreq_q;
    assign out_last  = olast_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign total     = total_q;
    assign err_range = err_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_freq_histogram.sv
// Bench for freq_histogram: a default instance and a CNT_W=2 instance share
// stimulus; results are compared against a counting model built from the
// symbol list.
module tb_freq_histogram;

    localparam int NS = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, skip_zero = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [3:0] data_in = '0;

    logic ov1, ol1, busy1, done1, err1, sat1;
    logic [3:0] sym1;
    logic [7:0] fr1;
    logic [11:0] tot1;
    logic ov2, ol2, busy2, done2, err2, sat2;
    logic [3:0] sym2;
    logic [1:0] fr2;
    logic [5:0] tot2;

    int n_chk = 0, n_fail = 0;
    int stim[$];
    int e1[NS], e2[NS];
    int lst[$];
    int etot1, etot2, eerr, esat1, esat2;

    always #5 clk = ~clk;

    freq_histogram dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_zero(skip_zero),
        .in_valid(in_valid), .in_last(in_last), .data_in(data_in),
        .out_valid(ov1), .out_ready(out_ready), .out_sym(sym1), .out_freq(fr1),
        .out_last(ol1), .busy(busy1), .done(done1), .total(tot1),
        .err_range(err1), .sat_flag(sat1)
    );

    freq_histogram #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_zero(skip_zero),
        .in_valid(in_valid), .in_last(in_last), .data_in(data_in),
        .out_valid(ov2), .out_ready(out_ready), .out_sym(sym2), .out_freq(fr2),
        .out_last(ol2), .busy(busy2), .done(done2), .total(tot2),
        .err_range(err2), .sat_flag(sat2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // expected histogram straight from the symbol list
    task automatic build_model(input bit skip);
        int t;
        t = 0; eerr = 0; esat1 = 0; esat2 = 0;
        for (int i = 0; i < NS; i++) begin e1[i] = 0; e2[i] = 0; end
        foreach (stim[k]) begin
            if (stim[k] >= NS) eerr = 1;
            else begin
                t++;
                if (e1[stim[k]] == 255) esat1 = 1; else e1[stim[k]]++;
                if (e2[stim[k]] == 3)   esat2 = 1; else e2[stim[k]]++;
            end
        end
        etot1 = (t > 4095) ? 4095 : t;
        etot2 = (t > 63) ? 63 : t;
        lst.delete();
        for (int i = 0; i < NS; i++)
            if (!skip || e1[i] != 0) lst.push_back(i);
    endtask

    // rmode: 0 ready held high, 1 toggling, 2 random
    task automatic run_hist(input bit skip, input int rmode, input bit mid_start);
        int nacc, ndone, ndone2, done_c, first_c, last_c;
        bit stall, r;
        logic [3:0] psym;
        logic [7:0] pfr;
        logic pl;
        build_model(skip);
        // symbol offered while idle/done must not be counted
        in_valid = 1'b1; data_in = 4'd2; in_last = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; skip_zero = skip; data_in = 4'd1;
        @(negedge clk);
        foreach (stim[k]) begin
            start     = mid_start && (k == 1);
            skip_zero = mid_start ? !skip : skip;
            in_valid  = 1'b1;
            data_in   = 4'(stim[k]);
            in_last   = (k == stim.size() - 1);
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        nacc = 0; ndone = 0; ndone2 = 0; done_c = -1; first_c = -1; last_c = -1; stall = 1'b0;
        psym = '0; pfr = '0; pl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 0) chk("busy_drain", busy1, 1);
            if (done1) begin ndone++; if (done_c < 0) done_c = c; end
            if (done2) ndone2++;
            if (stall) begin
                chk("stall_sym", sym1, psym);
                chk("stall_freq", fr1, pfr);
                chk("stall_last", ol1, pl);
            end
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            out_ready = r;
            if (ov1 && r) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                if (nacc < lst.size()) begin
                    chk("out_sym", sym1, lst[nacc]);
                    chk("out_freq", fr1, e1[lst[nacc]]);
                    chk("out_last", ol1, nacc == lst.size() - 1);
                    chk("out_valid2", ov2, 1);
                    chk("out_sym2", sym2, lst[nacc]);
                    chk("out_freq2", fr2, e2[lst[nacc]]);
                end else begin
                    chk("extra_entry", nacc, lst.size());
                end
                nacc++;
            end
            stall = ov1 && !r;
            psym = sym1; pfr = fr1; pl = ol1;
            if (done_c >= 0 && c >= done_c + 3) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("done_pulses", ndone, 1);
        chk("done_pulses2", ndone2, 1);
        chk("entries", nacc, lst.size());
        chk("total", tot1, etot1);
        chk("total2", tot2, etot2);
        chk("err_range", err1, eerr);
        chk("err_range2", err2, eerr);
        chk("sat_flag", sat1, esat1);
        chk("sat_flag2", sat2, esat2);
        chk("busy_done", busy1, 0);
        if (skip && lst.size() == 0) chk("zero_drain_time", (done_c >= 0 && done_c <= NS + 2), 1);
        if (!skip && rmode == 0) chk("throughput", last_c - first_c, NS - 1);
    endtask

    task automatic reset_mid_drain();
        int nacc, bad;
        nacc = 0; bad = 0;
        @(negedge clk);
        start = 1'b1; skip_zero = 1'b0;
        @(negedge clk);
        start = 1'b0;
        foreach (stim[k]) begin
            in_valid = 1'b1; data_in = 4'(stim[k]); in_last = (k == stim.size() - 1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && nacc < 2; c++) begin
            if (ov1) nacc++;
            @(negedge clk);
        end
        chk("rst_accepts", nacc, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", ov1, 0);
        chk("rst_sym", sym1, 0);
        chk("rst_freq", fr1, 0);
        chk("rst_last", ol1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_total", tot1, 0);
        chk("rst_flags", {err1, sat1}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (done1 || ov1 || busy1) bad++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("rst_no_done", bad, 0);
    endtask

    initial begin
        #1;
        chk("reset_valid", ov1, 0);
        chk("reset_busy", busy1, 0);
        chk("reset_total", tot1, 0);
        chk("reset_flags", {err1, sat1, done1, ol1}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stim = {3, 3, 7, 0, 3};
        run_hist(1'b0, 0, 1'b0);
        run_hist(1'b1, 1, 1'b0);
        stim = {4, 4, 4, 4, 4};
        run_hist(1'b0, 0, 1'b1);
        stim = {12};
        run_hist(1'b1, 0, 1'b0);
        stim = {3, 3, 7, 0, 3};
        reset_mid_drain();
        run_hist(1'b0, 2, 1'b0);

        stim.delete();
        for (int i = 0; i < 300; i++) stim.push_back(0);
        run_hist(1'b0, 2, 1'b0);

        for (int n = 0; n < 20; n++) begin
            int len;
            stim.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                stim.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            run_hist(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
